// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite word SRAM responder with programmable wait states.
// Build option: define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response
// for out-of-range or misaligned addresses. Without it, addresses wrap and
// HRESP is always OKAY.
// Ports: HCLK/HRESET (sync, active-high); HSEL, HADDR, HTRANS, HWRITE form
// the address phase; HWDATA is the write data phase; HRDATA, HRESP and
// HREADY_OUT form the response. HREADY_OUT also serves as the bus HREADY.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HRESP,
  output logic                  HREADY_OUT
);

  localparam int BL = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = (WAIT_STATES > 0) ?
                      $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WLAST =
    CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   a_idx;
  logic            a_err;
  logic            accept;
  state_t          a_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign HREADY_OUT = !(state == S_WAIT ||
                        state == S_ERR1);
  assign accept = HSEL & HTRANS[1] & HREADY_OUT;
  assign a_idx  = IW'(HADDR >> BL);

`ifdef AHB_SRAM_ERR_EN
  assign a_err =
    ((HADDR >> (BL + IW)) != '0) ||
    ((HADDR & ADDR_WIDTH'((1 << BL) - 1)) != '0);
  assign HRESP = {1'b0,
                  (state == S_ERR1 ||
                   state == S_ERR2)};
`else
  assign a_err = 1'b0;
  assign HRESP = 2'b00;
`endif

  // Destination of a freshly accepted address phase.
  always_comb begin
    a_next = S_DATA;
    if (a_err)
      a_next = S_ERR1;
    else if (WAIT_STATES > 0)
      a_next = S_WAIT;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_n = accept ? a_next : S_IDLE;
      end
      S_WAIT: begin
        if (cnt == WLAST)
          state_n = S_DATA;
        else
          cnt_n = cnt + CW'(1);
      end
      S_ERR1: state_n = S_ERR2;
      default: state_n = S_IDLE;
    endcase
    if (accept)
      cnt_n = '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        wr_q  <= HWRITE;
        idx_q <= a_idx;
      end
    end
  end

  // Write commits at the end of its data phase so a read
  // issued right behind it sees the new word.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && wr_q)
      mem[idx_q] <= HWDATA;
  end

  assign HRDATA = (state == S_DATA && !wr_q) ?
                  mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench for ahb_sram_slave.
// Two instances (0 and 2 wait states) share clock and reset.
module tb_ahb_sram_slave;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic [1:0]  hresp  [2];
  logic        hready [2];

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]),
    .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
    .HRDATA(hrdata[0]), .HRESP(hresp[0]),
    .HREADY_OUT(hready[0])
  );

  ahb_sram_slave #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]),
    .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
    .HRDATA(hrdata[1]), .HRESP(hresp[1]),
    .HREADY_OUT(hready[1])
  );

  typedef struct {
    int          at;
    int          d;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rd;
    string       nm;
  } exp_t;

  exp_t sb [$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_out(input int d, input int at,
                            input logic rdy,
                            input logic [1:0] resp,
                            input logic [31:0] rd,
                            input string nm);
    sb.push_back('{at, d, rdy, resp, rd, nm});
  endtask

  task automatic drive(input int d, input logic sel,
                       input logic [1:0] tr,
                       input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    hsel[d]   = sel;
    htrans[d] = tr;
    hwrite[d] = wr;
    haddr[d]  = a;
    hwdata[d] = wd;
  endtask

  // Monitor: compares every expectation due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checks++;
        if (sb[i].at < cyc) begin
          errors++;
          $display("FAIL %s: cycle %0d missed (now %0d)",
                   sb[i].nm, sb[i].at, cyc);
        end else if (hready[sb[i].d] !== sb[i].rdy ||
                     hresp[sb[i].d] !== sb[i].resp ||
                     hrdata[sb[i].d] !== sb[i].rd) begin
          errors++;
          $display("FAIL %s: cyc %0d got rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
                   sb[i].nm, cyc, hready[sb[i].d],
                   hresp[sb[i].d], hrdata[sb[i].d],
                   sb[i].rdy, sb[i].resp, sb[i].rd);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int c;
    hreset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d]   = 1'b0;
      htrans[d] = IDLE;
      hwrite[d] = 1'b0;
      haddr[d]  = '0;
      hwdata[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, cyc, 1'b1, 2'b00, 32'h0, "reset_ws0");
    expect_out(1, cyc, 1'b1, 2'b00, 32'h0, "reset_ws2");
    @(posedge clk);
    #1;
    hreset = 1'b0;

    // Zero-wait write then read of the same word.
    drive(0, 1, NONSEQ, 1, 32'h10, 32'h0);
    c = cyc;
    expect_out(0, c + 1, 1, 2'b00, 32'h0, "t1_wr_data");
    drive(0, 1, NONSEQ, 0, 32'h10, 32'hDEADBEEF);
    expect_out(0, c + 2, 1, 2'b00, 32'hDEADBEEF, "t1_rd_data");
    drive(0, 0, IDLE, 0, 32'h0, 32'h0);
    expect_out(0, c + 3, 1, 2'b00, 32'h0, "t1_idle");

    // Two wait states: write then read @0x04.
    drive(1, 1, NONSEQ, 1, 32'h04, 32'h0);
    c = cyc;
    expect_out(1, c + 1, 0, 2'b00, 32'h0, "t2_wr_wait1");
    expect_out(1, c + 2, 0, 2'b00, 32'h0, "t2_wr_wait2");
    expect_out(1, c + 3, 1, 2'b00, 32'h0, "t2_wr_data");
    repeat (3) drive(1, 0, IDLE, 0, 32'h0, 32'hCAFEF00D);
    drive(1, 1, NONSEQ, 0, 32'h04, 32'h0);
    expect_out(1, c + 4, 1, 2'b00, 32'h0, "t2_idle");
    expect_out(1, c + 5, 0, 2'b00, 32'h0, "t2_rd_wait1");
    expect_out(1, c + 6, 0, 2'b00, 32'h0, "t2_rd_wait2");
    expect_out(1, c + 7, 1, 2'b00, 32'hCAFEF00D, "t2_rd_data");
    repeat (3) drive(1, 0, IDLE, 0, 32'h0, 32'h0);

    // Reset during the wait of a write must not commit it.
    drive(1, 1, NONSEQ, 1, 32'h08, 32'h0);
    c = cyc;
    expect_out(1, c + 3, 1, 2'b00, 32'h0, "t6_wr1");
    repeat (3) drive(1, 0, IDLE, 0, 32'h0, 32'h11111111);
    drive(1, 1, NONSEQ, 1, 32'h08, 32'h0);
    c = cyc;
    drive(1, 0, IDLE, 0, 32'h0, 32'h22222222);
    hreset = 1'b1;
    expect_out(1, c + 1, 0, 2'b00, 32'h0, "t6_wait");
    drive(1, 0, IDLE, 0, 32'h0, 32'h22222222);
    hreset = 1'b0;
    expect_out(1, c + 2, 1, 2'b00, 32'h0, "t6_after_rst");
    drive(1, 1, BUSY, 1, 32'h08, 32'h33333333);
    expect_out(1, c + 4, 1, 2'b00, 32'h0, "t6_busy");
    drive(1, 1, NONSEQ, 0, 32'h08, 32'h33333333);
    expect_out(1, c + 5, 0, 2'b00, 32'h0, "t6_rd_wait1");
    expect_out(1, c + 7, 1, 2'b00, 32'h11111111, "t6_rd_data");
    repeat (3) drive(1, 0, IDLE, 0, 32'h0, 32'h0);

`ifdef AHB_SRAM_ERR_EN
    drive(0, 1, NONSEQ, 1, 32'h0, 32'h0);
    c = cyc;
    expect_out(0, c + 1, 1, 2'b00, 32'h0, "t3_wr_ok");
    drive(0, 0, IDLE, 0, 32'h0, 32'hA5A5A5A5);
    drive(0, 1, NONSEQ, 1, 32'h400, 32'h0);
    expect_out(0, c + 3, 0, 2'b01, 32'h0, "t3_err1");
    expect_out(0, c + 4, 1, 2'b01, 32'h0, "t3_err2");
    repeat (2) drive(0, 0, IDLE, 0, 32'h0, 32'h5A5A5A5A);
    drive(0, 1, NONSEQ, 0, 32'h02, 32'h0);
    expect_out(0, c + 6, 0, 2'b01, 32'h0, "t4_err1");
    expect_out(0, c + 7, 1, 2'b01, 32'h0, "t4_err2");
    repeat (2) drive(0, 0, IDLE, 0, 32'h0, 32'h0);
    drive(0, 1, NONSEQ, 0, 32'h0, 32'h0);
    expect_out(0, c + 9, 1, 2'b00, 32'hA5A5A5A5, "t3_mem0");
    drive(0, 0, IDLE, 0, 32'h0, 32'h0);
    // Errors bypass wait states.
    drive(1, 1, NONSEQ, 0, 32'h06, 32'h0);
    c = cyc;
    expect_out(1, c + 1, 0, 2'b01, 32'h0, "t4_ws_err1");
    expect_out(1, c + 2, 1, 2'b01, 32'h0, "t4_ws_err2");
    repeat (2) drive(1, 0, IDLE, 0, 32'h0, 32'h0);
`else
    drive(0, 1, NONSEQ, 1, 32'h400, 32'h0);
    c = cyc;
    expect_out(0, c + 1, 1, 2'b00, 32'h0, "t5_wr");
    drive(0, 0, IDLE, 0, 32'h0, 32'h1234);
    drive(0, 1, NONSEQ, 0, 32'h0, 32'h0);
    expect_out(0, c + 3, 1, 2'b00, 32'h1234, "t5_wrap");
    drive(0, 1, NONSEQ, 0, 32'h402, 32'h0);
    expect_out(0, c + 4, 1, 2'b00, 32'h1234, "t5_lowbits");
    drive(0, 0, IDLE, 0, 32'h0, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
